// File: rtl/druaga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : druaga_pkg
//  Description : Shared definitions for the Druaga ROM loader: loader FSM
//                state encoding, ioctl stream index constants and the DIP
//                switch packing function used by dip_packer.
//  Revision    : 1.0 - initial release
// ============================================================================
package druaga_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    localparam logic [7:0] IDX_ROM = 8'd0;
    localparam logic [7:0] IDX_TNO = 8'd1;
    localparam logic [7:0] IDX_DIP = 8'd254;

    // Titles 1..3 reuse nibbles of sw1/sw2 for the upper DIP bank.
    function automatic logic [23:0] dip_pack(
        input logic [3:0] tno,
        input logic [7:0] sw0,
        input logic [7:0] sw1,
        input logic [7:0] sw2
    );
        case (tno)
            4'd1, 4'd3: return {sw1[3:0], sw2[3:0], sw1, sw0};
            4'd2:       return {sw2[3:0], sw2[3:0], sw1, sw0};
            default:    return {sw2, sw1, sw0};
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dip_packer.sv
`default_nettype none
// ============================================================================
//  Module      : dip_packer
//  Description : Registers the packed 24-bit DIP switch word for the game
//                core from the title number and the first three DIP bytes.
//  Ports       : clk_sys    - system clock
//                RESET      - asynchronous active-high reset
//                tno        - title number
//                sw0..sw2   - DIP switch bytes
//                DSWs       - packed DIP word, updated one cycle after input
//  Revision    : 1.0 - initial release
// ============================================================================
module dip_packer
    import druaga_pkg::*;
(
    input  logic        clk_sys,
    input  logic        RESET,
    input  logic [3:0]  tno,
    input  logic [7:0]  sw0,
    input  logic [7:0]  sw1,
    input  logic [7:0]  sw2,
    output logic [23:0] DSWs
);

    logic [23:0] r_dsws;

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            r_dsws <= 24'd0;
        end else begin
            r_dsws <= dip_pack(tno, sw0, sw1, sw2);
        end
    end

    assign DSWs = r_dsws;

endmodule
`default_nettype wire

// File: rtl/druaga_rom_loader.sv
`default_nettype none
// ============================================================================
//  Module      : druaga_rom_loader
//  Description : Receives the HPS ioctl download stream and turns it into
//                ROM write strobes, title number and DIP switch settings for
//                the game core. The core is held in reset until a download
//                has finished and a hold period has elapsed.
//  Ports       : clk_sys, RESET          - clock, async active-high reset
//                ioctl_download/wr/addr/dout/index - HPS download stream
//                ROMAD/ROMDT/ROMEN       - ROM write port, 1-cycle latency
//                tno, DSWs               - title number, packed DIP switches
//                core_reset              - high except in RUN
//                rom_ready, rom_overflow - image complete / byte out of range
//                rom_sum, sum_valid      - only with ROM_CHECKSUM_EN defined
//  Config      : `define ROM_CHECKSUM_EN adds the modulo-256 ROM checksum.
//  Revision    : 1.0 - initial release
// ============================================================================
module druaga_rom_loader
    import druaga_pkg::*;
#(
    parameter logic [16:0] ROM_BYTES   = 17'h1_0000,
    parameter logic [15:0] HOLD_CYCLES = 16'd4096
) (
    input  logic        clk_sys,
    input  logic        RESET,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    output logic [16:0] ROMAD,
    output logic [7:0]  ROMDT,
    output logic        ROMEN,
    output logic [3:0]  tno,
    output logic [23:0] DSWs,
    output logic        core_reset,
    output logic        rom_ready,
`ifdef ROM_CHECKSUM_EN
    output logic [7:0]  rom_sum,
    output logic        sum_valid,
`endif
    output logic        rom_overflow
);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_dl_prev;
    logic        w_dl_rise;
    logic        w_dl_fall;
    logic [15:0] r_hold_cnt;
    logic [16:0] r_byte_cnt;
    logic [16:0] w_cnt_base;
    logic        w_rom_wr;
    logic        w_rom_in_range;
    logic        w_rom_acc;
    logic        w_rom_ovf;
    logic        w_tno_wr;
    logic        w_dip_wr;
    logic [16:0] r_romad;
    logic [7:0]  r_romdt;
    logic        r_romen;
    logic [3:0]  r_tno;
    logic [7:0]  r_sw0;
    logic [7:0]  r_sw1;
    logic [7:0]  r_sw2;
    logic        r_rom_ready;
    logic        r_rom_overflow;

    assign w_dl_rise = ioctl_download & ~r_dl_prev;
    assign w_dl_fall = ~ioctl_download & r_dl_prev;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            r_state   <= ST_IDLE;
            r_dl_prev <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_dl_prev <= ioctl_download;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        if (w_dl_rise) begin
            w_state_next = ST_LOAD;
        end else begin
            case (r_state)
                ST_LOAD: if (w_dl_fall)         w_state_next = ST_HOLD;
                ST_HOLD: if (r_hold_cnt == 16'd0) w_state_next = ST_RUN;
                default: w_state_next = r_state;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        core_reset = (r_state != ST_RUN);
`ifdef ROM_CHECKSUM_EN
        sum_valid  = (r_state == ST_RUN);
`endif
    end

    // Writes are judged against the next state so that a download edge in
    // the same cycle as a strobe takes effect before the byte is handled.
    assign w_rom_wr       = ioctl_wr && (w_state_next == ST_LOAD) && (ioctl_index == IDX_ROM);
    assign w_rom_in_range = (ioctl_addr < {8'd0, ROM_BYTES});
    assign w_rom_acc      = w_rom_wr & w_rom_in_range;
    assign w_rom_ovf      = w_rom_wr & ~w_rom_in_range;
    assign w_tno_wr       = ioctl_wr && ioctl_download && (ioctl_index == IDX_TNO);
    assign w_dip_wr       = ioctl_wr && (ioctl_index == IDX_DIP) && (ioctl_addr[24:3] == 22'd0);
    assign w_cnt_base     = w_dl_rise ? 17'd0 : r_byte_cnt;

    // ---------------- ROM path, counters and status ----------------
    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            r_romad        <= 17'd0;
            r_romdt        <= 8'd0;
            r_romen        <= 1'b0;
            r_hold_cnt     <= 16'd0;
            r_byte_cnt     <= 17'd0;
            r_rom_ready    <= 1'b0;
            r_rom_overflow <= 1'b0;
        end else begin
            r_romen <= w_rom_acc;
            if (w_rom_acc) begin
                r_romad <= ioctl_addr[16:0];
                r_romdt <= ioctl_dout;
            end

            if (r_state == ST_LOAD && w_state_next == ST_HOLD) begin
                r_hold_cnt <= HOLD_CYCLES;
            end else if (r_state == ST_HOLD && r_hold_cnt != 16'd0) begin
                r_hold_cnt <= r_hold_cnt - 16'd1;
            end

            // Saturating: never counts past a full image.
            if (w_rom_acc && w_cnt_base != ROM_BYTES) begin
                r_byte_cnt <= w_cnt_base + 17'd1;
            end else begin
                r_byte_cnt <= w_cnt_base;
            end

            r_rom_overflow <= (w_dl_rise ? 1'b0 : r_rom_overflow) | w_rom_ovf;

            if (w_dl_rise) begin
                r_rom_ready <= 1'b0;
            end else if (r_state == ST_HOLD && w_state_next == ST_RUN &&
                         r_byte_cnt == ROM_BYTES) begin
                r_rom_ready <= 1'b1;
            end
        end
    end

    // ---------------- Title and DIP capture ----------------
    // Only sw0..sw2 feed the packed word, so only those bytes are kept.
    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            r_tno <= 4'd0;
            r_sw0 <= 8'd0;
            r_sw1 <= 8'd0;
            r_sw2 <= 8'd0;
        end else begin
            if (w_tno_wr) begin
                r_tno <= ioctl_dout[3:0];
            end
            if (w_dip_wr) begin
                case (ioctl_addr[2:0])
                    3'd0:    r_sw0 <= ioctl_dout;
                    3'd1:    r_sw1 <= ioctl_dout;
                    3'd2:    r_sw2 <= ioctl_dout;
                    default: ;
                endcase
            end
        end
    end

`ifdef ROM_CHECKSUM_EN
    logic [7:0] r_sum;

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            r_sum <= 8'd0;
        end else begin
            r_sum <= (w_dl_rise ? 8'd0 : r_sum) + (w_rom_acc ? ioctl_dout : 8'd0);
        end
    end

    assign rom_sum = r_sum;
`endif

    dip_packer u_dip_packer (
        .clk_sys (clk_sys),
        .RESET   (RESET),
        .tno     (r_tno),
        .sw0     (r_sw0),
        .sw1     (r_sw1),
        .sw2     (r_sw2),
        .DSWs    (DSWs)
    );

    assign ROMAD        = r_romad;
    assign ROMDT        = r_romdt;
    assign ROMEN        = r_romen;
    assign tno          = r_tno;
    assign rom_ready    = r_rom_ready;
    assign rom_overflow = r_rom_overflow;

endmodule
`default_nettype wire

// File: tb/tb_druaga_rom_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_druaga_rom_loader
//  Description : Self-checking bench for druaga_rom_loader. Expected ROM
//                writes go into a scoreboard queue; a monitor pops and checks
//                address, data and 1-cycle latency on every ROMEN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_druaga_rom_loader;

`ifdef ROM_CHECKSUM_EN
    localparam int TB_ROM_BYTES = 256;
`else
    localparam int TB_ROM_BYTES = 65536;
`endif
    localparam int TB_HOLD = 4096;

    logic        clk_sys = 1'b0;
    logic        RESET = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [7:0]  ioctl_index = '0;
    logic [16:0] ROMAD;
    logic [7:0]  ROMDT;
    logic        ROMEN;
    logic [3:0]  tno;
    logic [23:0] DSWs;
    logic        core_reset;
    logic        rom_ready;
    logic        rom_overflow;
`ifdef ROM_CHECKSUM_EN
    logic [7:0]  rom_sum;
    logic        sum_valid;
`endif

    druaga_rom_loader #(
        .ROM_BYTES   (17'(TB_ROM_BYTES)),
        .HOLD_CYCLES (16'(TB_HOLD))
    ) dut (
        .clk_sys        (clk_sys),
        .RESET          (RESET),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .ROMAD          (ROMAD),
        .ROMDT          (ROMDT),
        .ROMEN          (ROMEN),
        .tno            (tno),
        .DSWs           (DSWs),
        .core_reset     (core_reset),
        .rom_ready      (rom_ready),
`ifdef ROM_CHECKSUM_EN
        .rom_sum        (rom_sum),
        .sum_valid      (sum_valid),
`endif
        .rom_overflow   (rom_overflow)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [16:0] a;
        logic [7:0]  d;
        int          c;
    } rom_wr_t;

    rom_wr_t q[$];
    int      cyc = 0;
    int      n_cmp = 0;
    int      n_err = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Scoreboard monitor
    always @(negedge clk_sys) begin
        if (ROMEN === 1'b1) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL romen_unexpected: got ROMAD=%h ROMDT=%h, required no ROMEN", ROMAD, ROMDT);
            end else begin
                rom_wr_t e;
                e = q.pop_front();
                if (ROMAD !== e.a || ROMDT !== e.d || cyc != e.c + 1) begin
                    n_err++;
                    $display("FAIL rom_write: got addr=%h data=%h cyc=%0d, required addr=%h data=%h cyc=%0d",
                             ROMAD, ROMDT, cyc, e.a, e.d, e.c + 1);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Drives one strobe for one cycle and leaves ioctl_wr high; caller drops it.
    task automatic wr_byte(input logic [7:0] idx, input logic [24:0] addr,
                           input logic [7:0] data, input bit expect_rom);
        rom_wr_t e;
        ioctl_index = idx;
        ioctl_addr  = addr;
        ioctl_dout  = data;
        ioctl_wr    = 1'b1;
        if (expect_rom) begin
            e.a = addr[16:0];
            e.d = data;
            e.c = cyc;
            q.push_back(e);
        end
        tick();
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_romen"},      32'(ROMEN), 32'd0);
        chk({tag, "_romad"},      32'(ROMAD), 32'd0);
        chk({tag, "_romdt"},      32'(ROMDT), 32'd0);
        chk({tag, "_tno"},        32'(tno), 32'd0);
        chk({tag, "_dsws"},       32'(DSWs), 32'd0);
        chk({tag, "_core_reset"}, 32'(core_reset), 32'd1);
        chk({tag, "_rom_ready"},  32'(rom_ready), 32'd0);
        chk({tag, "_overflow"},   32'(rom_overflow), 32'd0);
    endtask

    initial begin
        int n;

        // Power-on reset
        repeat (3) tick();
        chk_reset_values("por");
        RESET = 1'b0;
        tick();

        // Title and DIP download; tno write rides on the download rising edge
        ioctl_download = 1'b1;
        wr_byte(8'd1, 25'd0, 8'h02, 1'b0);
        wr_byte(8'd254, 25'd0, 8'h11, 1'b0);
        wr_byte(8'd254, 25'd1, 8'h22, 1'b0);
        wr_byte(8'd254, 25'd2, 8'hA5, 1'b0);
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
        tick();
        tick();
        chk("tno_2", 32'(tno), 32'h2);
        chk("dsws_tno2", 32'(DSWs), 32'h55_2211);
        chk("hold_core_reset", 32'(core_reset), 32'd1);

        // New download during HOLD
        repeat (10) tick();
        ioctl_download = 1'b1;
        tick();
        chk("rehold_core_reset", 32'(core_reset), 32'd1);
        chk("rehold_rom_ready", 32'(rom_ready), 32'd0);
        wr_byte(8'd1, 25'd0, 8'h00, 1'b0);
        ioctl_wr = 1'b0;
        tick();
        tick();
        chk("dsws_tno0", 32'(DSWs), 32'hA5_2211);

        // 100 bytes, then RESET together with byte 100
        for (int i = 0; i < 100; i++) wr_byte(8'd0, 25'(i), 8'(i + 8'h40), 1'b1);
        ioctl_wr = 1'b0;
        tick();
        chk("mid_core_reset", 32'(core_reset), 32'd1);
        ioctl_index = 8'd0;
        ioctl_addr  = 25'd100;
        ioctl_dout  = 8'h99;
        ioctl_wr    = 1'b1;
        RESET       = 1'b1;
        #1;
        chk_reset_values("async");
        ioctl_wr = 1'b0;
        tick();
        tick();

        // Release with download still high; first image byte in the same cycle
        RESET = 1'b0;
        for (int i = 0; i < TB_ROM_BYTES; i++) wr_byte(8'd0, 25'(i), 8'(i), 1'b1);
        ioctl_wr = 1'b0;
        tick();
        chk("load_core_reset", 32'(core_reset), 32'd1);
        ioctl_download = 1'b0;
        n = 0;
        tick();
        while (core_reset === 1'b1 && n < TB_HOLD + 100) begin
            n++;
            tick();
        end
        n_cmp++;
        if (n < TB_HOLD || n > TB_HOLD + 2) begin
            n_err++;
            $display("FAIL hold_length: got %0d cycles, required %0d..%0d", n, TB_HOLD, TB_HOLD + 2);
        end
        chk("run_core_reset", 32'(core_reset), 32'd0);
        chk("run_rom_ready", 32'(rom_ready), 32'd1);
        chk("run_overflow", 32'(rom_overflow), 32'd0);
        chk("sb_drained", 32'(q.size()), 32'd0);
`ifdef ROM_CHECKSUM_EN
        chk("rom_sum", 32'(rom_sum), 32'h80);
        chk("sum_valid", 32'(sum_valid), 32'd1);
`endif

        // Writes with download low: DIP accepted, others ignored
        wr_byte(8'd254, 25'd0, 8'h33, 1'b0);
        wr_byte(8'd254, 25'd8, 8'hFF, 1'b0);
        wr_byte(8'd1, 25'd0, 8'h03, 1'b0);
        wr_byte(8'd0, 25'd5, 8'h77, 1'b0);
        ioctl_wr = 1'b0;
        tick();
        tick();
        chk("dsws_idle_dip", 32'(DSWs), 32'h00_0033);
        chk("tno_ignored", 32'(tno), 32'd0);

        // Overflow byte at ROM_BYTES, last valid byte, sticky then cleared
        ioctl_download = 1'b1;
        tick();
        tick();
        chk("start_rom_ready", 32'(rom_ready), 32'd0);
        wr_byte(8'd0, 25'(TB_ROM_BYTES), 8'hEE, 1'b0);
        ioctl_wr = 1'b0;
        tick();
        chk("overflow_set", 32'(rom_overflow), 32'd1);
        wr_byte(8'd0, 25'(TB_ROM_BYTES - 1), 8'h5A, 1'b1);
        ioctl_wr = 1'b0;
        tick();
        tick();
        chk("overflow_sticky", 32'(rom_overflow), 32'd1);
        ioctl_download = 1'b0;
        tick();
        tick();
        chk("overflow_hold", 32'(rom_overflow), 32'd1);
        ioctl_download = 1'b1;
        tick();
        tick();
        chk("overflow_cleared", 32'(rom_overflow), 32'd0);
        chk("sb_final", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
